// File: rtl/led_frame_scheduler_if.sv
// Byte stream from the frame scheduler to the LED serializer.
// The scheduler drives everything except out_ready.
interface led_frame_scheduler_if #(
    parameter int unsigned DEV_W = 5
);
    logic [7:0]       out_data;
    logic [DEV_W-1:0] out_dev;
    logic             out_last;
    logic             out_frame_last;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output out_data, out_dev, out_last, out_frame_last, out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data, out_dev, out_last, out_frame_last, out_valid,
        output out_ready
    );
endinterface

// File: rtl/led_frame_scheduler.sv
// Read-side sequencer: walks every frame RAM bank in device order and streams each byte,
// tagged with device index and last flags, to the LED serializer.
module led_frame_scheduler #(
    parameter int unsigned NUM_DEVICES = 20,
    parameter int unsigned DEV_W       = 5,
    parameter int unsigned DEPTH       = 512,
    parameter int unsigned AW          = 9
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [9:0]            bytes_per_dev,
    output logic                  rd_en,
    output logic [AW-1:0]         raddr,
    output logic [DEV_W-1:0]      rd_dev,
    input  logic [7:0]            ram_dout,
    led_frame_scheduler_if.master out_if,
    output logic                  busy,
    output logic                  done,
    output logic                  overrun
);

    localparam logic [9:0]       MaxLen  = 10'(DEPTH);
    localparam logic [DEV_W-1:0] LastDev = DEV_W'(NUM_DEVICES - 1);

    typedef enum logic [2:0] {StIdle, StFetch, StLatch, StPresent, StDone} state_e;

    state_e           state_q, state_d;
    logic [9:0]       len_q, len_d;
    logic [DEV_W-1:0] dev_q, dev_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [7:0]       out_data_q, out_data_d;
    logic [DEV_W-1:0] out_dev_q, out_dev_d;
    logic             out_last_q, out_last_d;
    logic             out_frame_last_q, out_frame_last_d;
    logic             done_q, done_d;

    logic [9:0] start_len;
    logic       hs;

    assign start_len = (bytes_per_dev > MaxLen) ? MaxLen : bytes_per_dev;
    assign hs        = (state_q == StPresent) && out_if.out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (start) state_d = (start_len == 10'd0) ? StDone : StFetch;
            StFetch:   state_d = StLatch;
            StLatch:   state_d = StPresent;
            StPresent: if (hs) state_d = out_frame_last_q ? StDone : StFetch;
            StDone:    state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    always_comb begin
        len_d            = len_q;
        dev_d            = dev_q;
        addr_d           = addr_q;
        out_data_d       = out_data_q;
        out_dev_d        = out_dev_q;
        out_last_d       = out_last_q;
        out_frame_last_d = out_frame_last_q;
        done_d           = (state_q == StDone);
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    len_d  = start_len;
                    dev_d  = '0;
                    addr_d = '0;
                end
            end
            StLatch: begin
                out_data_d       = ram_dout;
                out_dev_d        = dev_q;
                out_last_d       = (10'(addr_q) == len_q - 10'd1);
                out_frame_last_d = out_last_d && (dev_q == LastDev);
            end
            StPresent: begin
                // On the frame-last byte the counters are left alone; IDLE reloads them.
                if (hs && !out_frame_last_q) begin
                    if (out_last_q) begin
                        dev_d  = dev_q + DEV_W'(1);
                        addr_d = '0;
                    end else begin
                        addr_d = addr_q + AW'(1);
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            len_q            <= '0;
            dev_q            <= '0;
            addr_q           <= '0;
            out_data_q       <= '0;
            out_dev_q        <= '0;
            out_last_q       <= 1'b0;
            out_frame_last_q <= 1'b0;
            done_q           <= 1'b0;
        end else begin
            len_q            <= len_d;
            dev_q            <= dev_d;
            addr_q           <= addr_d;
            out_data_q       <= out_data_d;
            out_dev_q        <= out_dev_d;
            out_last_q       <= out_last_d;
            out_frame_last_q <= out_frame_last_d;
            done_q           <= done_d;
        end
    end

    always_comb begin
        rd_en            = 1'b0;
        raddr            = '0;
        rd_dev           = '0;
        busy             = 1'b0;
        out_if.out_valid = 1'b0;
        unique case (state_q)
            StFetch: begin
                rd_en  = 1'b1;
                raddr  = addr_q;
                rd_dev = dev_q;
                busy   = 1'b1;
            end
            StLatch:   busy = 1'b1;
            StPresent: begin
                busy             = 1'b1;
                out_if.out_valid = 1'b1;
            end
            default: ;
        endcase
    end

    assign overrun               = start && (state_q != StIdle);
    assign done                  = done_q;
    assign out_if.out_data       = out_data_q;
    assign out_if.out_dev        = out_dev_q;
    assign out_if.out_last       = out_last_q;
    assign out_if.out_frame_last = out_frame_last_q;

endmodule

// File: tb/tb_led_frame_scheduler.sv
// Scoreboard bench for led_frame_scheduler: expected bytes are queued at start and
// compared on every handshake against a behavioural model of the preloaded RAM banks.
module tb_led_frame_scheduler;

    localparam int ND    = 20;
    localparam int DEV_W = 5;
    localparam int AW    = 9;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             start = 1'b0;
    logic [9:0]       bytes_per_dev = '0;
    logic             rd_en;
    logic [AW-1:0]    raddr;
    logic [DEV_W-1:0] rd_dev;
    logic [7:0]       ram_dout = '0;
    logic             busy, done, overrun;

    led_frame_scheduler_if #(.DEV_W(DEV_W)) out_if ();

    led_frame_scheduler #(
        .NUM_DEVICES(ND), .DEV_W(DEV_W), .DEPTH(512), .AW(AW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .bytes_per_dev (bytes_per_dev),
        .rd_en         (rd_en),
        .raddr         (raddr),
        .rd_dev        (rd_dev),
        .ram_dout      (ram_dout),
        .out_if        (out_if),
        .busy          (busy),
        .done          (done),
        .overrun       (overrun)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int start_cyc, done_cyc;
    int done_cnt = 0, rd_cnt = 0, vld_cnt = 0;
    int max_raddr = 0;
    int ready_mode = 0;
    logic [14:0] sb[$];
    logic [14:0] cur, exp_v, hold_val;
    bit          hold_vld = 1'b0;
    logic [7:0]  mem [ND][512];

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        for (int d = 0; d < ND; d++)
            for (int a = 0; a < 512; a++) mem[d][a] = 8'(d * 16 + a);
    end

    // Synchronous-read RAM: data one clock after rd_en.
    always @(posedge clk) if (rd_en && rd_dev < DEV_W'(ND)) ram_dout <= mem[rd_dev][raddr];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] outs_vec();
        return 64'({rd_en, raddr, rd_dev, out_if.out_data, out_if.out_dev, out_if.out_last,
                    out_if.out_frame_last, out_if.out_valid, busy, done, overrun});
    endfunction

    initial begin
        out_if.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_if.out_ready = (ready_mode == 0) ? 1'b1 : (cyc % 3 == 0);
        end
    end

    always @(negedge clk) begin
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (rd_en) begin
            rd_cnt++;
            if (int'(raddr) > max_raddr) max_raddr = int'(raddr);
        end
        if (out_if.out_valid) begin
            vld_cnt++;
            cur = {out_if.out_data, out_if.out_dev, out_if.out_last, out_if.out_frame_last};
            if (hold_vld) check("hold_stable", 64'(cur), 64'(hold_val));
            if (out_if.out_ready) begin
                hold_vld = 1'b0;
                if (sb.size() == 0) begin
                    check("sb_underflow", 64'(sb.size()), 64'd1);
                end else begin
                    exp_v = sb.pop_front();
                    check("byte", 64'(cur), 64'(exp_v));
                end
            end else begin
                hold_vld = 1'b1;
                hold_val = cur;
            end
        end else begin
            hold_vld = 1'b0;
        end
    end

    task automatic do_start(input int bpd, input bit expect_frame);
        int len;
        @(posedge clk);
        #1;
        bytes_per_dev = 10'(bpd);
        start         = 1'b1;
        start_cyc     = cyc;
        len           = (bpd > 512) ? 512 : bpd;
        if (expect_frame)
            for (int d = 0; d < ND; d++)
                for (int a = 0; a < len; a++)
                    sb.push_back({8'(d * 16 + a), DEV_W'(d), a == len - 1,
                                  (a == len - 1) && (d == ND - 1)});
        @(posedge clk);
        #1;
        start         = 1'b0;
        bytes_per_dev = 10'd1;  // must not affect the frame in flight
    endtask

    task automatic wait_done(input int budget);
        int  d0 = done_cnt;
        bit  ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(posedge clk);
            if (done_cnt != d0) ok = 1'b1;
        end
        check("done_seen", 64'(ok), 64'd1);
    endtask

    initial begin
        int r0, v0, d0;
        #4 reset = 1'b1;
        #2 check("rst_outs_a", outs_vec(), 64'd0);
        #10 check("rst_outs_b", outs_vec(), 64'd0);
        #4 check("rst_outs_c", outs_vec(), 64'd0);
        #1 reset = 1'b0;
        @(negedge clk);
        check("idle_outs", outs_vec(), 64'd0);

        // Three bytes per device, ready always high.
        do_start(3, 1'b1);
        wait_done(400);
        check("lat_len3", 64'(done_cyc - start_cyc), 64'(3 * 3 * ND + 2));
        check("sb_empty_1", 64'(sb.size()), 64'd0);

        // Same frame, ready high one cycle in three.
        ready_mode = 1;
        do_start(3, 1'b1);
        wait_done(1500);
        check("sb_empty_2", 64'(sb.size()), 64'd0);
        ready_mode = 0;

        // Zero-length frame.
        r0 = rd_cnt;
        v0 = vld_cnt;
        do_start(0, 1'b1);
        wait_done(20);
        check("lat_len0", 64'(done_cyc - start_cyc), 64'd2);
        check("len0_reads", 64'(rd_cnt - r0), 64'd0);
        check("len0_valid", 64'(vld_cnt - v0), 64'd0);

        // Over-length request clamps to a full bank.
        max_raddr = 0;
        do_start(700, 1'b1);
        wait_done(40000);
        check("max_raddr", 64'(max_raddr), 64'd511);
        check("lat_len512", 64'(done_cyc - start_cyc), 64'(3 * 512 * ND + 2));
        check("sb_empty_3", 64'(sb.size()), 64'd0);

        // Start while busy: overrun pulse, frame unaffected.
        d0 = done_cnt;
        do_start(3, 1'b1);
        repeat (10) @(posedge clk);
        #1 start = 1'b1;
        @(negedge clk);
        check("overrun", 64'(overrun), 64'd1);
        check("busy", 64'(busy), 64'd1);
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(400);
        check("lat_overrun", 64'(done_cyc - start_cyc), 64'(3 * 3 * ND + 2));
        check("done_once", 64'(done_cnt - d0), 64'd1);
        check("sb_empty_4", 64'(sb.size()), 64'd0);

        // Reset mid-frame: everything drops, no done, restart from device 0.
        do_start(3, 1'b1);
        repeat (20) @(posedge clk);
        #3 reset = 1'b1;
        #1 check("midrst_outs", outs_vec(), 64'd0);
        d0 = done_cnt;
        @(posedge clk);
        #1 reset = 1'b0;
        sb.delete();
        repeat (10) @(posedge clk);
        check("midrst_no_done", 64'(done_cnt - d0), 64'd0);
        do_start(3, 1'b1);
        wait_done(400);
        check("lat_restart", 64'(done_cyc - start_cyc), 64'(3 * 3 * ND + 2));
        check("sb_empty_5", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

endmodule
